// File: rtl/seg_pkg.sv
// seg_pkg: shared state type, defaults and width helper for the serial segment shifter
package seg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_CLK_DIV = 2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/seg_sclk_div.sv
// seg_sclk_div: bit-period divider producing the registered s_clk level and the last-cycle strobe
module seg_sclk_div import seg_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_ph,
  output logic end_ph
);
  localparam int DW = clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV);
  logic [DW-1:0] div_cnt, div_nxt;
  always_comb begin
    end_ph = en && div_cnt == LAST;
    div_nxt = (en && !end_ph) ? div_cnt + DW'(1) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt <= '0;
      rise_ph <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      rise_ph <= div_nxt >= HALF;
    end
endmodule

// File: rtl/seg_serial_shifter.sv
// seg_serial_shifter: shifts a mapped segment word MSB-first onto a serial 7-seg chain, then latches it
module seg_serial_shifter import seg_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] par_data,
  output logic              busy,
  output logic              done,
  output logic              s_clk,
  output logic              s_dout,
  output logic              s_latch,
  output logic              s_clrn
);
  localparam int BW = clog2(DATA_W + 1);
  localparam int LW = clog2(CLK_DIV + 1);
  state_t state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic [LW-1:0] lat_cnt;
  logic shift_en, end_ph, last_bit, lat_end;
  logic busy_d, done_d, latch_d, dout_d;
  assign shift_en = state == SHIFT;
  assign last_bit = end_ph && bit_cnt == BW'(DATA_W - 1);
  assign lat_end = state == LATCH && lat_cnt == LW'(CLK_DIV - 1);
  seg_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .rst(rst),
    .en(shift_en),
    .rise_ph(s_clk),
    .end_ph(end_ph)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
                state == SHIFT ? (last_bit ? LATCH : SHIFT) :
                                 (lat_end ? IDLE : LATCH);
  always_comb begin
    busy_d = state_nxt != IDLE;
    done_d = lat_end;
    latch_d = state_nxt == LATCH;
    dout_d = state == IDLE  ? start && par_data[DATA_W-1] :
             state == SHIFT ? (end_ph ? !last_bit && shreg[DATA_W-2] : s_dout) :
                              1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg <= '0;
      bit_cnt <= '0;
      lat_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      s_dout <= 1'b0;
      s_latch <= 1'b0;
      s_clrn <= 1'b0;
    end else begin
      shreg <= (state == IDLE && start) ? par_data : end_ph ? shreg << 1 : shreg;
      bit_cnt <= state == IDLE ? '0 : end_ph ? bit_cnt + BW'(1) : bit_cnt;
      lat_cnt <= state == LATCH ? lat_cnt + LW'(1) : '0;
      busy <= busy_d;
      done <= done_d;
      s_dout <= dout_d;
      s_latch <= latch_d;
      s_clrn <= 1'b1;
    end
endmodule

// File: tb/tb_seg_serial_shifter.sv
// tb_seg_serial_shifter: randomized and directed checks of two shifter instances against a frame-position model
module tb_seg_serial_shifter;
  localparam int W = 64;
  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] par_data;
  logic [1:0] busy, done, sclk, sdout, latch, clrn;
  int cd[2] = '{2, 1};
  int npass = 0, ntot = 0;
  logic [W-1:0] mw[2];
  int mn[2];
  bit mfr[2];
  bit mclrn;
  int busy_c[2] = '{0, 0}, done_c[2] = '{0, 0}, latch_c[2] = '{0, 0}, rise_c[2] = '{0, 0};
  int s_busy[2], s_done[2], s_latch[2], s_rise[2];
  logic [W-1:0] cap[2] = '{64'd0, 64'd0};
  logic [1:0] sclk_q = 2'b00;
  always #5 clk = ~clk;
  seg_serial_shifter dut0 (
    .clk(clk), .rst(rst), .start(start), .par_data(par_data),
    .busy(busy[0]), .done(done[0]), .s_clk(sclk[0]), .s_dout(sdout[0]),
    .s_latch(latch[0]), .s_clrn(clrn[0])
  );
  seg_serial_shifter #(.DATA_W(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .par_data(par_data),
    .busy(busy[1]), .done(done[1]), .s_clk(sclk[1]), .s_dout(sdout[1]),
    .s_latch(latch[1]), .s_clrn(clrn[1])
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [5:0] dv(input int i);
    return {busy[i], done[i], sclk[i], sdout[i], latch[i], clrn[i]};
  endfunction
  function automatic logic [5:0] expv(input int i);
    int n = mn[i];
    int c = cd[i];
    int f = 2 * c * W;
    logic b, d, k, o, l;
    b = mfr[i] && n >= 1 && n <= f + c;
    d = mfr[i] && n == f + c + 1;
    k = mfr[i] && n >= 1 && n <= f && ((n - 1) % (2 * c)) >= c;
    o = (mfr[i] && n >= 1 && n <= f) ? mw[i][W - 1 - (n - 1) / (2 * c)] : 1'b0;
    l = mfr[i] && n > f && n <= f + c;
    return {b, d, k, o, l, mclrn};
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      mclrn = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mfr[i] = 1'b0;
        mn[i] = 0;
      end
    end else begin
      mclrn = 1'b1;
      for (int i = 0; i < 2; i++)
        if (!mfr[i] || mn[i] == 2 * cd[i] * W + cd[i] + 1) begin
          mfr[i] = start;
          mn[i] = start ? 1 : 0;
          if (start) mw[i] = par_data;
        end else mn[i]++;
    end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("outs_dut%0d", i), 64'(dv(i)), 64'(expv(i)));
      busy_c[i] += int'(busy[i]);
      done_c[i] += int'(done[i]);
      latch_c[i] += int'(latch[i]);
      if (sclk[i] && !sclk_q[i]) begin
        cap[i] = {cap[i][W-2:0], sdout[i]};
        rise_c[i]++;
      end
      sclk_q[i] = sclk[i];
    end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      s_busy[i] = busy_c[i];
      s_done[i] = done_c[i];
      s_latch[i] = latch_c[i];
      s_rise[i] = rise_c[i];
    end
  endtask
  task automatic wait_done0(input int max);
    int k = 0;
    while (!done[0] && k < max) begin
      cyc(1);
      k++;
    end
    chk("wait_done0", 64'(k < max), 64'd1);
  endtask
  task automatic frame_checks(input logic [W-1:0] w);
    int bl[2] = '{258, 129};
    int ll[2] = '{2, 1};
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("capture_dut%0d", i), cap[i], w);
      chk($sformatf("rises_dut%0d", i), 64'(rise_c[i] - s_rise[i]), 64'd64);
      chk($sformatf("busy_len_dut%0d", i), 64'(busy_c[i] - s_busy[i]), 64'(bl[i]));
      chk($sformatf("latch_len_dut%0d", i), 64'(latch_c[i] - s_latch[i]), 64'(ll[i]));
      chk($sformatf("done_cnt_dut%0d", i), 64'(done_c[i] - s_done[i]), 64'd1);
    end
  endtask
  task automatic frame(input logic [W-1:0] w);
    par_data = w;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    snap();
    wait_done0(400);
    cyc(5);
    frame_checks(w);
  endtask
  initial begin
    logic [W-1:0] w;
    rst = 1'b1;
    start = 1'b0;
    par_data = '0;
    cyc(2);
    chk("reset_outs", 64'({dv(0), dv(1)}), 64'd0);
    rst = 1'b0;
    cyc(1);
    chk("clrn_rise", 64'({clrn[0], clrn[1]}), 64'b11);
    frame({$urandom, $urandom});
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(50);
    #2;
    rst = 1'b1;
    #1;
    chk("midcycle_rst_outs", 64'({dv(0), dv(1)}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("clrn_low_after_release", 64'({clrn[0], clrn[1]}), 64'd0);
    cyc(1);
    chk("clrn_one_clk_later", 64'({clrn[0], clrn[1]}), 64'b11);
    frame(64'h8000_0000_0000_0001);
    frame(64'hA5A5_F00F_0FF0_5A5A);
    w = {$urandom, $urandom};
    par_data = w;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    snap();
    cyc(9);
    par_data = ~w;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(89);
    par_data = {$urandom, $urandom};
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done0(400);
    cyc(5);
    frame_checks(w);
    par_data = {$urandom, $urandom};
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(122);
    chk("pre_rst_sclk_busy", 64'({sclk[0], busy[0], busy[1]}), 64'b111);
    snap();
    #3;
    rst = 1'b1;
    #1;
    chk("bit30_rst_dut0", 64'({busy[0], sclk[0], latch[0], done[0], sdout[0], clrn[0]}), 64'd0);
    chk("bit30_rst_dut1", 64'({busy[1], sclk[1], latch[1], done[1], sdout[1], clrn[1]}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(10);
    chk("no_done_after_rst", 64'({done_c[0] - s_done[0], done_c[1] - s_done[1]}), 64'd0);
    frame({$urandom, $urandom});
    snap();
    start = 1'b1;
    repeat (600) begin
      cyc(1);
      par_data = {$urandom, $urandom};
    end
    start = 1'b0;
    chk("held_start_frames_dut0", 64'(done_c[0] - s_done[0]), 64'd2);
    chk("held_start_frames_dut1", 64'(done_c[1] - s_done[1]), 64'd4);
    cyc(300);
    repeat (1500) begin
      start = ($urandom % 20) == 0;
      rst = ($urandom % 400) == 0;
      par_data = {$urandom, $urandom};
      cyc(1);
    end
    rst = 1'b0;
    start = 1'b0;
    cyc(300);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
